// File: rtl/sap1e_pkg.sv
// Shared definitions for the SAP-1E program loader: FSM encoding, frame header
// and sticky error codes.
package sap1e_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_COUNT  = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_VERIFY = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } loader_state_t;

  localparam logic [7:0] LOADER_HDR = 8'hA5;

  localparam logic [1:0] LOADER_ERR_NONE   = 2'd0;
  localparam logic [1:0] LOADER_ERR_CSUM   = 2'd1;
  localparam logic [1:0] LOADER_ERR_VERIFY = 2'd2;
  localparam logic [1:0] LOADER_ERR_COUNT  = 2'd3;

  // States in which a new load may be started.
  function automatic logic loader_can_start(input loader_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
  endfunction

  // States that consume bytes from the stream.
  function automatic logic loader_accepts(input loader_state_t s);
    return (s == ST_HDR) || (s == ST_COUNT) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/loader_sum.sv
// Clearable, enabled modulo-2^DATA_WIDTH accumulator used for both the write
// checksum and the readback sum.
module loader_sum #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] sum,
  output logic [DATA_WIDTH-1:0] sum_next
);

  // sum_next lets the caller judge the final word in the same cycle it arrives.
  assign sum_next = sum + din;

  always_ff @(posedge clock) begin
    if (clear) begin
      sum <= '0;
    end else if (enable) begin
      sum <= sum_next;
    end
  end

endmodule

// File: rtl/ram_loader.sv
// Program-RAM loader: accepts a framed byte stream (header, count, data,
// checksum), writes it to RAM, then reads it back to verify.
module ram_loader
  import sap1e_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  loading,
  output logic                  done,
  output logic [1:0]            error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = DATA_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

  loader_state_t state;

  // Extra top bit lets a full-depth load finish without wrapping to 0.
  logic [ADDR_WIDTH:0]   addr_cnt;
  logic [ADDR_WIDTH:0]   addr_inc;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_in;
  logic                  count_bad;
  logic                  last_word;
  logic [DATA_WIDTH-1:0] expected;

  logic                  xfer;
  logic                  start_ok;
  logic                  hdr_match;
  logic                  csum_match;

  logic                  sum_clear;
  logic                  sum_en;
  logic [DATA_WIDTH-1:0] sum_in;
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] sum_next;

  assign rx_ready   = loader_accepts(state);
  assign xfer       = rx_valid && rx_ready;
  assign start_ok   = start && loader_can_start(state);
  assign hdr_match  = (rx_data == DATA_WIDTH'(LOADER_HDR));
  assign csum_match = (rx_data == sum);

  // A count byte of zero stands for a full-depth image.
  assign count_in  = (rx_data == '0) ? DEPTH_W : {1'b0, rx_data};
  assign count_bad = (count_in > DEPTH_W);

  assign addr_inc  = addr_cnt + (ADDR_WIDTH + 1)'(1);
  assign last_word = (CW'(addr_inc) == count);

  always_comb begin
    sum_clear = 1'b0;
    sum_en    = 1'b0;
    sum_in    = rx_data;
    if (start_ok) begin
      sum_clear = 1'b1;
    end else begin
      case (state)
        ST_DATA:   sum_en    = xfer;
        ST_CSUM:   sum_clear = xfer && csum_match;
        ST_VERIFY: begin
          sum_en = 1'b1;
          sum_in = ram_rdata;
        end
        default: ;
      endcase
    end
  end

  loader_sum #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sum (
    .clock    (clock),
    .clear    (sum_clear),
    .enable   (sum_en),
    .din      (sum_in),
    .sum      (sum),
    .sum_next (sum_next)
  );

  // Frame length and reference checksum are pure data; no reset needed.
  always_ff @(posedge clock) begin
    if (state == ST_COUNT && xfer) begin
      count <= count_in;
    end
    if (state == ST_CSUM && xfer) begin
      expected <= sum;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      addr_cnt  <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      loading   <= 1'b0;
      done      <= 1'b0;
      error     <= LOADER_ERR_NONE;
    end else begin
      ram_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state    <= ST_HDR;
            addr_cnt <= '0;
            loading  <= 1'b1;
            done     <= 1'b0;
            error    <= LOADER_ERR_NONE;
          end
        end

        // Anything other than the header byte is dropped to resync.
        ST_HDR: begin
          if (xfer && hdr_match) begin
            state <= ST_COUNT;
          end
        end

        ST_COUNT: begin
          if (xfer) begin
            if (count_bad) begin
              state   <= ST_ERR;
              error   <= LOADER_ERR_COUNT;
              loading <= 1'b0;
            end else begin
              state <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (xfer) begin
            ram_we    <= 1'b1;
            ram_addr  <= addr_cnt[ADDR_WIDTH-1:0];
            ram_wdata <= rx_data;
            addr_cnt  <= addr_inc;
            if (last_word) begin
              state <= ST_CSUM;
            end
          end
        end

        // Address 0 is presented on the edge into VERIFY so the first
        // readback word is available in VERIFY's first cycle.
        ST_CSUM: begin
          if (xfer) begin
            if (!csum_match) begin
              state   <= ST_ERR;
              error   <= LOADER_ERR_CSUM;
              loading <= 1'b0;
            end else begin
              state    <= ST_VERIFY;
              addr_cnt <= '0;
              ram_addr <= '0;
            end
          end
        end

        ST_VERIFY: begin
          if (last_word) begin
            loading <= 1'b0;
            if (sum_next == expected) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_ERR;
              error <= LOADER_ERR_VERIFY;
            end
          end else begin
            addr_cnt <= addr_inc;
            ram_addr <= addr_inc[ADDR_WIDTH-1:0];
          end
        end

        default: begin
          state   <= ST_IDLE;
          loading <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader paired with a combinational-read RAM model.
module tb_ram_loader;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic [7:0] ram_rdata;
  logic       loading;
  logic       done;
  logic [1:0] error;

  logic       poke_en;
  logic [3:0] poke_addr;
  logic [7:0] poke_data;
  logic [7:0] mem [16];

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  checks;
  int  errors;
  int  verify_cycles;

  ram_loader #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .loading   (loading),
    .done      (done),
    .error     (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model; the poke port lets the bench corrupt a word behind the loader.
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    else if (poke_en) mem[poke_addr] <= poke_data;
  end
  assign ram_rdata = mem[ram_addr];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected write for every RAM write pulse.
  always @(negedge clock) begin
    wr_t e;
    if (reset_n && loading && !rx_ready) verify_cycles++;
    if (reset_n && ram_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 ram_addr, ram_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", int'(ram_addr), int'(e.a));
        check("wr_data", int'(ram_wdata), int'(e.d));
      end
    end
  end

  task automatic expect_wr(input logic [3:0] a, input logic [7:0] d);
    exp_q.push_back('{a: a, d: d});
  endtask

  task automatic pulse_start();
    @(negedge clock);
    verify_cycles = 0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("loading_after_start", int'(loading), 1);
  endtask

  // Called on a negedge; returns on the negedge after the byte transfers.
  task automatic send(input logic [7:0] b);
    int t;
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (!rx_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) check("rx_ready_timeout", 0, 1);
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    rx_valid = 1'b0;
    rx_data  = 8'hEE;
    repeat (n) @(negedge clock);
  endtask

  task automatic finish_load(input string name, input int exp_done, input int exp_err,
                             input int exp_vcyc);
    int t;
    t = 0;
    while (loading && t < 100) begin
      @(negedge clock);
      t++;
    end
    check({name, "_loading_fell"}, int'(loading), 0);
    check({name, "_done"}, int'(done), exp_done);
    check({name, "_error"}, int'(error), exp_err);
    check({name, "_verify_cycles"}, verify_cycles, exp_vcyc);
    repeat (2) @(negedge clock);
    check({name, "_writes_outstanding"}, exp_q.size(), 0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    start     = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    poke_en   = 1'b0;
    poke_addr = 4'd0;
    poke_data = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_rx_ready", int'(rx_ready), 0);
    check("rst_ram_we", int'(ram_we), 0);
    check("rst_loading", int'(loading), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    check("rst_ram_addr", int'(ram_addr), 0);
    check("rst_ram_wdata", int'(ram_wdata), 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Nominal load
    pulse_start();
    send(8'hA5);
    send(8'h03);
    expect_wr(4'd0, 8'h11); send(8'h11);
    expect_wr(4'd1, 8'h22); send(8'h22);
    expect_wr(4'd2, 8'h33); send(8'h33);
    send(8'h66);
    finish_load("nominal", 1, 0, 3);
    check("nominal_mem0", int'(mem[0]), 'h11);
    check("nominal_mem2", int'(mem[2]), 'h33);

    // Full depth: count 0 means 16 words, checksum 0x78
    pulse_start();
    send(8'hA5);
    send(8'h00);
    for (int i = 0; i < 16; i++) begin
      expect_wr(4'(i), 8'(i));
      send(8'(i));
    end
    send(8'h78);
    finish_load("full", 1, 0, 16);
    check("full_mem0", int'(mem[0]), 'h00);
    check("full_mem15", int'(mem[15]), 'h0F);

    // Resync and back-pressure
    pulse_start();
    send(8'hFF); gap(2);
    send(8'h12); gap(1);
    send(8'hA5); gap(3);
    send(8'h01); gap(1);
    expect_wr(4'd0, 8'h5A); send(8'h5A); gap(2);
    send(8'h5A);
    finish_load("resync", 1, 0, 1);

    // Checksum error
    pulse_start();
    send(8'hA5);
    send(8'h02);
    expect_wr(4'd0, 8'h01); send(8'h01);
    expect_wr(4'd1, 8'h02); send(8'h02);
    send(8'h04);
    finish_load("csum_err", 0, 1, 0);

    // Bad count (17 > 16)
    pulse_start();
    send(8'hA5);
    send(8'h11);
    finish_load("count_err", 0, 3, 0);
    check("count_err_rx_ready", int'(rx_ready), 0);

    // Verify fault: address 1 corrupted after the checksum is accepted
    pulse_start();
    send(8'hA5);
    send(8'h02);
    expect_wr(4'd0, 8'hAA); send(8'hAA);
    expect_wr(4'd1, 8'hBB); send(8'hBB);
    send(8'h65);
    poke_addr = 4'd1;
    poke_data = 8'h00;
    poke_en   = 1'b1;
    @(negedge clock);
    poke_en   = 1'b0;
    finish_load("verify_err", 0, 2, 2);

    // Reset in the middle of DATA
    pulse_start();
    send(8'hA5);
    send(8'h04);
    expect_wr(4'd0, 8'h01); send(8'h01);
    expect_wr(4'd1, 8'h02); send(8'h02);
    #2;
    check("mid_we_before_reset", int'(ram_we), 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ram_we", int'(ram_we), 0);
    check("mid_rst_loading", int'(loading), 0);
    check("mid_rst_rx_ready", int'(rx_ready), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_error", int'(error), 0);
    check("mid_rst_ram_addr", int'(ram_addr), 0);
    check("mid_rst_ram_wdata", int'(ram_wdata), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("after_reset_loading", int'(loading), 0);

    pulse_start();
    send(8'hA5);
    send(8'h03);
    expect_wr(4'd0, 8'h11); send(8'h11);
    expect_wr(4'd1, 8'h22); send(8'h22);
    expect_wr(4'd2, 8'h33); send(8'h33);
    send(8'h66);
    finish_load("post_reset", 1, 0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
